// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings and helpers for the sram-like bus arbiter.
// Imported by the arbiter, its ID FIFO and the bench.
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Sram-like bus bundle for N channels (req/addr_ok/data_ok).
// The master modport is the requester side, slave the responder side.
interface sram_like_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N-1:0]          req;
    logic [N-1:0]          wr;
    logic [2*N-1:0]        size;
    logic [N*DATA_W/8-1:0] wstrb;
    logic [N*ADDR_W-1:0]   addr;
    logic [N*DATA_W-1:0]   wdata;
    logic [N-1:0]          addr_ok;
    logic [N-1:0]          data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// Synchronous FIFO holding the master ID of each accepted transaction.
// Push while full and pop while empty are ignored.
module sram_like_arbiter_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave sram-like bus arbiter with in-order responses
// routed back to the issuing master through an ID FIFO.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_OUTST   = 4,
    parameter int RR_MODE     = 1
) (
    input  logic clk,
    input  logic resetn,
    sram_like_arbiter_if.slave  m,
    sram_like_arbiter_if.master s,
    output logic err
);

    localparam int IDW = id_width(NUM_MASTERS);
    localparam int SW  = DATA_W / 8;
    localparam int CW  = $clog2(MAX_OUTST) + 1;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;

    logic [IDW-1:0]   arb_gnt, gnt, idx, head;
    logic             found;
    logic             s_req, hs, stall, pop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;

    logic             s_wr;
    logic [1:0]       s_size;
    logic [SW-1:0]    s_wstrb;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [NUM_MASTERS-1:0] m_addr_ok, m_data_ok;

    // First requester at or after rr_ptr (RR) or lowest index (fixed)
    always_comb begin
        arb_gnt = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (RR_MODE != 0)
                idx = IDW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
            else
                idx = IDW'(i);
            if (!found && m.req[idx]) begin
                found   = 1'b1;
                arb_gnt = idx;
            end
        end
    end

    assign gnt   = (state_q == ST_LOCK) ? lock_id_q : arb_gnt;
    assign s_req = ((state_q == ST_LOCK) || (|m.req)) && !fifo_full;
    assign hs    = s_req && s.addr_ok[0];
    assign stall = s_req && !s.addr_ok[0];
    assign pop   = s.data_ok[0] && (fifo_cnt != '0);

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt == IDW'(i)) begin
                s_wr    = m.wr[i];
                s_size  = m.size[i*2 +: 2];
                s_wstrb = m.wstrb[i*SW +: SW];
                s_addr  = m.addr[i*ADDR_W +: ADDR_W];
                s_wdata = m.wdata[i*DATA_W +: DATA_W];
                m_addr_ok[i] = hs;
            end
            m_data_ok[i] = pop && (head == IDW'(i));
        end
    end

    assign s.req     = s_req;
    assign s.wr      = s_wr;
    assign s.size    = s_size;
    assign s.wstrb   = s_wstrb;
    assign s.addr    = s_addr;
    assign s.wdata   = s_wdata;
    assign m.addr_ok = m_addr_ok;
    assign m.data_ok = m_data_ok;
    assign m.rdata   = s.rdata;
    assign err       = err_q;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q;
        unique case (1'b1)
            hs: begin
                state_d = ST_ARB;
                if (RR_MODE != 0)
                    rr_ptr_d = (gnt == IDW'(NUM_MASTERS - 1))
                             ? '0 : gnt + 1'b1;
            end
            stall: begin
                state_d   = ST_LOCK;
                lock_id_d = gnt;
            end
            default: ;
        endcase
        if (s.data_ok[0] && fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_ARB;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    sram_like_arbiter_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (pop),
        .din    (gnt),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .cnt    (fifo_cnt)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a round-robin arbiter (A) and a fixed-priority
// arbiter (B) driven with identical master/slave stimulus.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic err_a, err_b;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sram_like_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) ma ();
    sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) sa ();
    sram_like_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) mb ();
    sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) sb ();

    sram_like_arbiter #(
        .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32),
        .MAX_OUTST(4), .RR_MODE(1)
    ) u_a (
        .clk(clk), .resetn(resetn),
        .m(ma), .s(sa), .err(err_a)
    );

    sram_like_arbiter #(
        .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32),
        .MAX_OUTST(4), .RR_MODE(0)
    ) u_b (
        .clk(clk), .resetn(resetn),
        .m(mb), .s(sb), .err(err_b)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input bit req, input bit wr,
                         input logic [31:0] addr,
                         input logic [31:0] wdata);
        ma.req[i] = req;   mb.req[i] = req;
        ma.wr[i]  = wr;    mb.wr[i]  = wr;
        ma.size[i*2 +: 2]  = SIZE_WORD;
        mb.size[i*2 +: 2]  = SIZE_WORD;
        ma.wstrb[i*4 +: 4] = wr ? 4'hF : 4'h0;
        mb.wstrb[i*4 +: 4] = wr ? 4'hF : 4'h0;
        ma.addr[i*32 +: 32]  = addr;  mb.addr[i*32 +: 32]  = addr;
        ma.wdata[i*32 +: 32] = wdata; mb.wdata[i*32 +: 32] = wdata;
    endtask

    task automatic set_s(input bit aok, input bit dok,
                         input logic [31:0] rdata);
        sa.addr_ok = aok; sb.addr_ok = aok;
        sa.data_ok = dok; sb.data_ok = dok;
        sa.rdata = rdata; sb.rdata = rdata;
    endtask

    task automatic clear_in();
        set_m(0, 0, 0, 32'h0, 32'h0);
        set_m(1, 0, 0, 32'h0, 32'h0);
        set_s(0, 0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_sreq", sa.req, 1'b0);
        chk("rst_aok", ma.addr_ok, 2'b00);
        chk("rst_dok", ma.data_ok, 2'b00);
        chk("rst_err", err_a, 1'b0);

        // single read from master 0
        @(negedge clk);
        set_m(0, 1, 0, 32'h1C00_0000, 32'h0);
        set_s(1, 0, 32'h0);
        #1;
        chk("rd_sreq", sa.req, 1'b1);
        chk("rd_addr", sa.addr, 32'h1C00_0000);
        chk("rd_swr", sa.wr, 1'b0);
        chk("rd_aok", ma.addr_ok, 2'b01);
        @(negedge clk);
        clear_in();
        #1;
        chk("rd_aok_off", ma.addr_ok, 2'b00);
        chk("rd_dok_wait", ma.data_ok, 2'b00);
        @(negedge clk);
        set_s(0, 1, 32'hDEAD_BEEF);
        #1;
        chk("rd_dok", ma.data_ok, 2'b01);
        chk("rd_rdata", ma.rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        clear_in();
        #1;
        chk("rd_dok_off", ma.data_ok, 2'b00);

        // both masters request, slave always ready
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_m(0, 1, 0, 32'h0000_0100, 32'h0);
            set_m(1, 1, 0, 32'h0000_0200, 32'h0);
            set_s(1, 0, 32'h0);
            #1;
            chk("rr_aok", ma.addr_ok, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_addr", sa.addr,
                (c % 2 == 0) ? 32'h100 : 32'h200);
            chk("fp_aok", mb.addr_ok, 2'b01);
        end
        // four outstanding: FIFO full
        @(negedge clk);
        #1;
        chk("full_sreq", sa.req, 1'b0);
        chk("full_aok", ma.addr_ok, 2'b00);
        @(negedge clk);
        set_s(1, 1, 32'hA0);
        #1;
        chk("full_nobypass", sa.req, 1'b0);
        chk("full_dok", ma.data_ok, 2'b01);
        @(negedge clk);
        set_s(1, 1, 32'hA1);
        #1;
        chk("pp_sreq", sa.req, 1'b1);
        chk("pp_aok", ma.addr_ok, 2'b01);
        chk("pp_dok", ma.data_ok, 2'b10);
        @(negedge clk);
        set_s(1, 0, 32'h0);
        #1;
        chk("pp_cnt_kept", sa.req, 1'b1);
        chk("pp_aok2", ma.addr_ok, 2'b10);
        @(negedge clk);
        #1;
        chk("refull_sreq", sa.req, 1'b0);

        // stall with lock on master 1
        do_reset();
        @(negedge clk);
        set_m(1, 1, 0, 32'h2222_0000, 32'h0);
        #1;
        chk("stl_addr1", sa.addr, 32'h2222_0000);
        chk("stl_aok1", ma.addr_ok, 2'b00);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_m(0, 1, 0, 32'h1111_0000, 32'h0);
            #1;
            chk("stl_lock_addr", sa.addr, 32'h2222_0000);
        end
        @(negedge clk);
        set_s(1, 0, 32'h0);
        #1;
        chk("stl_acc1", ma.addr_ok, 2'b10);
        chk("stl_acc1_addr", sa.addr, 32'h2222_0000);
        @(negedge clk);
        set_m(1, 0, 0, 32'h0, 32'h0);
        #1;
        chk("stl_acc0", ma.addr_ok, 2'b01);
        chk("stl_acc0_addr", sa.addr, 32'h1111_0000);
        @(negedge clk);
        clear_in();
        set_s(0, 1, 32'h5);
        #1;
        chk("stl_rsp1", ma.data_ok, 2'b10);
        @(negedge clk);
        #1;
        chk("stl_rsp0", ma.data_ok, 2'b01);

        // interleaved issue m0,m1(write),m1,m0
        do_reset();
        @(negedge clk);
        set_m(0, 1, 0, 32'h10, 32'h0);
        set_s(1, 0, 32'h0);
        #1;
        chk("il_aok0", ma.addr_ok, 2'b01);
        @(negedge clk);
        set_m(0, 0, 0, 32'h0, 32'h0);
        set_m(1, 1, 1, 32'h20, 32'hCAFE_F00D);
        #1;
        chk("il_aok1", ma.addr_ok, 2'b10);
        chk("il_swr", sa.wr, 1'b1);
        chk("il_wdata", sa.wdata, 32'hCAFE_F00D);
        chk("il_wstrb", sa.wstrb, 4'hF);
        chk("il_size", sa.size, SIZE_WORD);
        @(negedge clk);
        set_m(1, 1, 0, 32'h30, 32'h0);
        #1;
        chk("il_aok2", ma.addr_ok, 2'b10);
        @(negedge clk);
        set_m(1, 0, 0, 32'h0, 32'h0);
        set_m(0, 1, 0, 32'h40, 32'h0);
        #1;
        chk("il_aok3", ma.addr_ok, 2'b01);
        @(negedge clk);
        clear_in();
        set_s(0, 1, 32'h11);
        #1;
        chk("il_dok0", ma.data_ok, 2'b01);
        chk("il_rd0", ma.rdata, 32'h11);
        @(negedge clk);
        set_s(0, 1, 32'h22);
        #1;
        chk("il_dok1", ma.data_ok, 2'b10);
        chk("il_rd1", ma.rdata, 32'h22);
        @(negedge clk);
        set_s(0, 1, 32'h33);
        #1;
        chk("il_dok2", ma.data_ok, 2'b10);
        chk("il_rd2", ma.rdata, 32'h33);
        @(negedge clk);
        set_s(0, 1, 32'h44);
        #1;
        chk("il_dok3", ma.data_ok, 2'b01);
        chk("il_rd3", ma.rdata, 32'h44);

        // spurious response sets sticky err
        @(negedge clk);
        set_s(0, 1, 32'h55);
        #1;
        chk("sp_dok", ma.data_ok, 2'b00);
        chk("sp_err_pre", err_a, 1'b0);
        @(negedge clk);
        clear_in();
        #1;
        chk("sp_err", err_a, 1'b1);
        @(negedge clk);
        #1;
        chk("sp_err_sticky", err_a, 1'b1);
        do_reset();
        #1;
        chk("sp_err_clr", err_a, 1'b0);

        // reset with a transaction outstanding
        @(negedge clk);
        set_m(0, 1, 0, 32'h60, 32'h0);
        set_s(1, 0, 32'h0);
        #1;
        chk("mr_aok", ma.addr_ok, 2'b01);
        do_reset();
        @(negedge clk);
        set_s(0, 1, 32'h66);
        #1;
        chk("mr_dok", ma.data_ok, 2'b00);
        @(negedge clk);
        clear_in();
        #1;
        chk("mr_err", err_a, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
